// File: rtl/operand_entry_seq.sv
`default_nettype none
// ============================================================================
// Module      : operand_entry_seq
// Description : Operand-capture front end for the 4-bit adder / 7-segment
//               display stage. Synchronises the slider switches and two
//               active-low pushbuttons and debounces the buttons. A small
//               sequencer then captures operand A, operand B and carry-in,
//               one "next" press at a time. The "clear" button returns the
//               sequencer to A and zeroes all captured operands.
//
// Ports       : clk_i         - system clock (50 MHz)
//               rst_n_i       - asynchronous active-low reset
//               sw_i[3:0]     - raw slider switches (asynchronous)
//               key_next_n_i  - raw next/capture button, active-low, bouncy
//               key_clr_n_i   - raw clear button, active-low, bouncy
//               a_o[3:0]      - operand A to adder stage
//               b_o[3:0]      - operand B to adder stage
//               cin_o         - carry-in to adder stage
//               stage_o[1:0]  - sequencer state (A=00 B=01 CIN=10 SHOW=11)
//               valid_o       - high while in SHOW (all operands captured)
//
// Parameters  : DB_CYCLES     - cycles a synchronised key level must differ
//                               from the debounced level before it is
//                               accepted (>= 2)
//
// Build option: OPERAND_LIVE_PREVIEW_EN - when defined, the operand being
//               entered follows the synchronised switches live (through one
//               extra output flop) while the sequencer waits in its state.
//
// Revision    : 1.0 - initial release
// ============================================================================
module operand_entry_seq #(
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] sw_i,
  input  logic       key_next_n_i,
  input  logic       key_clr_n_i,
  output logic [3:0] a_o,
  output logic [3:0] b_o,
  output logic       cin_o,
  output logic [1:0] stage_o,
  output logic       valid_o
);

  localparam int                 c_cnt_w    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DB_CYCLES - 1);
  localparam int                 c_num_keys = 2;
  localparam int                 c_key_next = 0;
  localparam int                 c_key_clr  = 1;

  typedef enum logic [1:0] {
    ST_A    = 2'b00,
    ST_B    = 2'b01,
    ST_CIN  = 2'b10,
    ST_SHOW = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Switch synchroniser: the whole nibble moves through the same two flops so
  // the four bits are always sampled together.
  // --------------------------------------------------------------------------
  logic [3:0] r_sw_s1;
  logic [3:0] r_sw_s2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sw_s1 <= 4'h0;
      r_sw_s2 <= 4'h0;
    end else begin
      r_sw_s1 <= sw_i;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-key synchroniser, debouncer and press detector.
  // --------------------------------------------------------------------------
  logic [c_num_keys-1:0] w_key_raw;
  logic [c_num_keys-1:0] w_press;

  assign w_key_raw[c_key_next] = key_next_n_i;
  assign w_key_raw[c_key_clr]  = key_clr_n_i;

  for (genvar gi = 0; gi < c_num_keys; gi++) begin : g_key
    logic               r_s1;
    logic               r_s2;
    logic               r_db;
    logic               r_db_prev;
    logic               r_pulse;
    logic [c_cnt_w-1:0] r_cnt;

    // Synchroniser and debounced level reset to "released" so a key already
    // held at reset release is seen as a fresh press once it is debounced.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_s1      <= 1'b1;
        r_s2      <= 1'b1;
        r_db      <= 1'b1;
        r_db_prev <= 1'b1;
        r_pulse   <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_s1 <= w_key_raw[gi];
        r_s2 <= r_s1;

        // Any cycle where the input agrees with the debounced level restarts
        // the count, so bounces shorter than DB_CYCLES are discarded.
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end

        // One-cycle pulse on the debounced 1->0 edge only; releases and
        // continued holding produce nothing.
        r_db_prev <= r_db;
        r_pulse   <= r_db_prev & ~r_db;
      end
    end

    assign w_press[gi] = r_pulse;
  end

  logic w_next_pulse;
  logic w_clr_pulse;

  assign w_next_pulse = w_press[c_key_next];
  assign w_clr_pulse  = w_press[c_key_clr];

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_a_q;
  logic [3:0] r_b_q;
  logic       r_cin_q;
  logic [3:0] w_a_nx;
  logic [3:0] w_b_nx;
  logic       w_cin_nx;
  logic       r_valid;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_A;
      r_a_q   <= 4'h0;
      r_b_q   <= 4'h0;
      r_cin_q <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_a_q   <= w_a_nx;
      r_b_q   <= w_b_nx;
      r_cin_q <= w_cin_nx;
      r_valid <= (w_state_nx == ST_SHOW);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a_q;
    w_b_nx     = r_b_q;
    w_cin_nx   = r_cin_q;

    // Clear takes priority over a coincident next press: nothing is captured.
    if (w_clr_pulse) begin
      w_state_nx = ST_A;
      w_a_nx     = 4'h0;
      w_b_nx     = 4'h0;
      w_cin_nx   = 1'b0;
    end else if (w_next_pulse) begin
      case (r_state)
        ST_A: begin
          w_a_nx     = r_sw_s2;
          w_state_nx = ST_B;
        end
        ST_B: begin
          w_b_nx     = r_sw_s2;
          w_state_nx = ST_CIN;
        end
        ST_CIN: begin
          w_cin_nx   = r_sw_s2[0];
          w_state_nx = ST_SHOW;
        end
        default: begin
          // SHOW: wrap round; captured operands stay until overwritten.
          w_state_nx = ST_A;
        end
      endcase
    end
  end

  assign stage_o = r_state;
  assign valid_o = r_valid;

  // --------------------------------------------------------------------------
  // Operand outputs
  // --------------------------------------------------------------------------
`ifdef OPERAND_LIVE_PREVIEW_EN
  // The preview flop is loaded from next-state values so captured operands
  // appear on the same edge as in the plain build; only the operand being
  // entered tracks the synchronised switches.
  logic [3:0] r_a_o;
  logic [3:0] r_b_o;
  logic       r_cin_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a_o   <= 4'h0;
      r_b_o   <= 4'h0;
      r_cin_o <= 1'b0;
    end else begin
      r_a_o   <= (w_state_nx == ST_A)   ? r_sw_s2    : w_a_nx;
      r_b_o   <= (w_state_nx == ST_B)   ? r_sw_s2    : w_b_nx;
      r_cin_o <= (w_state_nx == ST_CIN) ? r_sw_s2[0] : w_cin_nx;
    end
  end

  assign a_o   = r_a_o;
  assign b_o   = r_b_o;
  assign cin_o = r_cin_o;
`else
  assign a_o   = r_a_q;
  assign b_o   = r_b_q;
  assign cin_o = r_cin_q;
`endif

endmodule
`default_nettype wire
